// File: rtl/cache_pkg.sv
// Shared types and address field helpers for the L1 instruction cache.
package cache_pkg;

  localparam int LLC_LINE_BITS = 512;

  // Tags are held at full address width so the struct fits any cache geometry.
  typedef struct packed {
    logic                     valid;
    logic [63:0]              tag;
    logic [LLC_LINE_BITS-1:0] data;
  } icache_line_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    MISS   = 2'd2
  } icache_state_t;

  function automatic logic [63:0] addr_tag(input logic [63:0] addr,
                                           input int offset_size, input int index_size);
    return addr >> (offset_size + index_size);
  endfunction

  function automatic logic [63:0] addr_index(input logic [63:0] addr,
                                             input int offset_size, input int index_size);
    return (addr >> offset_size) & ((64'd1 << index_size) - 64'd1);
  endfunction

  function automatic logic [63:0] addr_word(input logic [63:0] addr, input int offset_size);
    return (addr >> 2) & ((64'd1 << (offset_size - 2)) - 64'd1);
  endfunction

  function automatic logic [63:0] line_base(input logic [63:0] addr, input int offset_size);
    return addr & ~((64'd1 << offset_size) - 64'd1);
  endfunction

endpackage

// File: rtl/l1i_line_store.sv
// Line array: valid/tag/data per line, async read, one write port, clear-all.
module l1i_line_store
  import cache_pkg::*;
#(
  parameter int LINE_COUNT = 32,
  parameter int INDEX_SIZE = $clog2(LINE_COUNT)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic [INDEX_SIZE-1:0]    rd_index,
  output logic                     rd_valid,
  output logic [63:0]              rd_tag,
  output logic [LLC_LINE_BITS-1:0] rd_data,
  input  logic                     wr_en,
  input  logic [INDEX_SIZE-1:0]    wr_index,
  input  logic [63:0]              wr_tag,
  input  logic [LLC_LINE_BITS-1:0] wr_data
);

  logic [LINE_COUNT-1:0]    valid_q;
  logic [63:0]              tag_q  [LINE_COUNT];
  logic [LLC_LINE_BITS-1:0] data_q [LINE_COUNT];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
    end else if (clear) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_index] <= 1'b1;
    end
  end

  // Tag/data carry no reset; the valid bit alone qualifies them.
  always_ff @(posedge clk) begin
    if (wr_en && !clear) begin
      tag_q[wr_index]  <= wr_tag;
      data_q[wr_index] <= wr_data;
    end
  end

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_data  = data_q[rd_index];

endmodule

// File: rtl/l1_icache.sv
// Direct-mapped read-only L1 instruction cache with blocking miss to the LLC S1 port.
module l1_icache
  import cache_pkg::*;
#(
  parameter int LINE_COUNT     = 32,
  parameter int BYTES_PER_LINE = 64,
  parameter int INDEX_SIZE     = $clog2(LINE_COUNT),
  parameter int OFFSET_SIZE    = $clog2(BYTES_PER_LINE),
  parameter int TAG_SIZE       = 64 - INDEX_SIZE - OFFSET_SIZE
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [63:0]              fetch_addr,
  input  logic                     fetch_valid,
  output logic                     fetch_ready,
  output logic [31:0]              instr_data,
  output logic                     instr_valid,
  output logic                     instr_fault,
  input  logic                     flush,
  output logic [63:0]              llc_r_addr,
  output logic                     llc_r_addr_valid,
  input  logic [LLC_LINE_BITS-1:0] llc_r_data,
  input  logic                     llc_r_data_valid,
  output logic [31:0]              hit_count,
  output logic [31:0]              miss_count,
  output logic [1:0]               state
);

  icache_state_t            state_q, state_d;
  logic [63:0]              req_addr_q, req_addr_d;
  logic [31:0]              hit_cnt_q, miss_cnt_q;
  logic                     replay_q;
  logic                     fill, hit_inc, miss_inc, hit, misaligned;
  icache_line_t             line;
  logic [INDEX_SIZE-1:0]    req_index;
  logic [OFFSET_SIZE-3:0]   req_word;
  logic [63:0]              req_tag;

  assign req_index  = INDEX_SIZE'(addr_index(req_addr_q, OFFSET_SIZE, INDEX_SIZE));
  assign req_word   = (OFFSET_SIZE-2)'(addr_word(req_addr_q, OFFSET_SIZE));
  assign req_tag    = addr_tag(req_addr_q, OFFSET_SIZE, INDEX_SIZE);
  assign misaligned = (req_addr_q[1:0] != 2'b00);
  assign hit        = line.valid && (line.tag == req_tag);

  l1i_line_store #(.LINE_COUNT(LINE_COUNT), .INDEX_SIZE(INDEX_SIZE)) u_store (
    .clk      (clk),
    .reset    (reset),
    .clear    (flush),
    .rd_index (req_index),
    .rd_valid (line.valid),
    .rd_tag   (line.tag),
    .rd_data  (line.data),
    .wr_en    (fill),
    .wr_index (req_index),
    .wr_tag   (req_tag),
    .wr_data  (llc_r_data)
  );

  always_comb begin
    state_d          = state_q;
    req_addr_d       = req_addr_q;
    fetch_ready      = 1'b0;
    instr_valid      = 1'b0;
    instr_fault      = 1'b0;
    instr_data       = '0;
    llc_r_addr       = '0;
    llc_r_addr_valid = 1'b0;
    fill             = 1'b0;
    hit_inc          = 1'b0;
    miss_inc         = 1'b0;
    case (state_q)
      IDLE: begin
        fetch_ready = 1'b1;
        if (fetch_valid) begin
          req_addr_d = fetch_addr;
          state_d    = LOOKUP;
        end
      end
      LOOKUP: begin
        if (misaligned || hit) begin
          instr_valid = 1'b1;
          instr_fault = misaligned;
          instr_data  = misaligned ? 32'd0 : line.data[{req_word, 5'b00000} +: 32];
          // The post-fill replay was already counted as a miss.
          hit_inc     = hit && !misaligned && !replay_q;
          fetch_ready = 1'b1;
          if (fetch_valid) req_addr_d = fetch_addr;
          else             state_d    = IDLE;
        end else begin
          miss_inc = 1'b1;
          state_d  = MISS;
        end
      end
      MISS: begin
        llc_r_addr       = line_base(req_addr_q, OFFSET_SIZE);
        llc_r_addr_valid = 1'b1;
        if (llc_r_data_valid) begin
          fill    = 1'b1;
          state_d = LOOKUP;
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d          = IDLE;
      fetch_ready      = 1'b0;
      instr_valid      = 1'b0;
      instr_fault      = 1'b0;
      instr_data       = '0;
      llc_r_addr       = '0;
      llc_r_addr_valid = 1'b0;
      fill             = 1'b0;
      hit_inc          = 1'b0;
      miss_inc         = 1'b0;
    end
    if (!reset) fetch_ready = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      req_addr_q <= '0;
      replay_q   <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      req_addr_q <= req_addr_d;
      replay_q   <= fill;
      if (hit_inc && (hit_cnt_q != 32'hFFFF_FFFF))   hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (miss_inc && (miss_cnt_q != 32'hFFFF_FFFF)) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
  assign state      = state_q;

endmodule

// File: doc/l1_icache.md
# l1_icache

Direct-mapped, read-only L1 instruction cache between the core's fetch stage and the LLC's S1 read port. It serves 32-bit instruction fetches from resident lines at one per cycle. On a miss it holds a line-aligned address on the LLC S1 port until the LLC reports the line valid, then installs the 512-bit line and replays the fetch. It also provides whole-cache invalidate and saturating hit/miss counters.

## Interface
Parameters:
- LINE_COUNT, 32: number of lines.
- BYTES_PER_LINE, 64: line size. Must equal the LLC line size (512 bits).
- INDEX_SIZE, $clog2(LINE_COUNT): index width.
- OFFSET_SIZE, $clog2(BYTES_PER_LINE): byte-offset width.
- TAG_SIZE, 64-INDEX_SIZE-OFFSET_SIZE: tag width.

Ports:
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low (0 = reset).
- fetch_addr  in  64  byte address of the instruction.
- fetch_valid  in  1  fetch request present.
- fetch_ready  out  1  request accepted on an edge where fetch_valid && fetch_ready.
- instr_data  out  32  instruction word.
- instr_valid  out  1  instr_data/instr_fault valid this cycle; single-cycle pulse; no backpressure.
- instr_fault  out  1  fetch_addr[1:0] != 0 (misaligned).
- flush  in  1  invalidate all lines.
- llc_r_addr  out  64  line-aligned miss address (drives LLC S1_R_ADDR).
- llc_r_addr_valid  out  1  drives LLC S1_R_ADDR_VALID.
- llc_r_data  in  512  LLC S1_R_DATA.
- llc_r_data_valid  in  1  LLC S1_R_DATA_VALID (line for llc_r_addr is resident in the LLC).
- hit_count, miss_count  out  32  saturating counters.

## Operation
- Storage per line: valid bit, tag, and 512-bit data. Read is combinational by index.
- Address fields: tag = addr[63:OFFSET_SIZE+INDEX_SIZE]; index = addr[OFFSET_SIZE+INDEX_SIZE-1:OFFSET_SIZE]; word w = addr[OFFSET_SIZE-1:2].
- Word selection: instr_data = data[32w+31:32w], little-endian word order.
- FSM states:
  - IDLE: fetch_ready=1. An accepted request is registered into req_addr and the FSM moves to LOOKUP.
  - LOOKUP: hit = valid && tag match on req_addr.
    - Misaligned request: instr_valid=1, instr_fault=1, instr_data=0. No LLC access, no counter change. Treated as a hit for ready purposes.
    - Hit: instr_valid=1, hit_count+1, fetch_ready=1. A new accept reloads req_addr and stays in LOOKUP; otherwise go to IDLE.
    - Miss: fetch_ready=0, miss_count+1, go to MISS.
  - MISS: llc_r_addr = {req tag, req index, OFFSET_SIZE'b0}, llc_r_addr_valid=1, fetch_ready=0. When llc_r_data_valid is sampled high, write llc_r_data, tag and valid=1 at the req index, then go to LOOKUP. The replay hits; it does not increment hit_count.
- flush (has priority over everything):
  - Next edge: all valid bits cleared and FSM goes to IDLE.
  - Any request in LOOKUP/MISS is dropped: no instr_valid, and llc_r_addr_valid falls.
  - fetch_ready=0 while flush=1.
  - A fill coinciding with flush is discarded.
- Counters saturate at 32'hFFFF_FFFF. They are not cleared by flush.

## Timing
- Reset values: state IDLE, all valid bits 0, fetch_ready 1 after reset releases (0 during reset), instr_valid 0, instr_fault 0, instr_data 0, llc_r_addr 0, llc_r_addr_valid 0, counters 0.
- Data array is not reset.
- Hit latency: accepted at edge N, instr_valid in cycle N+1. Back-to-back hits sustain 1 fetch/cycle.
- Miss latency: detected in cycle N+1, request in cycle N+2. If llc_r_data_valid=1 in N+2, the fill occurs at the end of N+2 and instr_valid appears in N+3. Each extra LLC cycle adds 1.
- llc_r_addr is stable for the entire time llc_r_addr_valid=1. It is only deasserted by a fill or by flush.
- Reset asserted mid-miss: everything returns to reset values immediately (asynchronous); no pending state survives.

## Structure
- Shared cache_pkg:
  - icache_line_t packed struct {valid, tag, data}.
  - icache_state_t enum {IDLE, LOOKUP, MISS}.
  - Field-extract functions parameterized by OFFSET_SIZE/INDEX_SIZE.
- One sub-module, l1i_line_store: line array with asynchronous read port, one write port, and a clear-all input driven by flush.

## Test plan
- Cold miss: reset, fetch 0x1000; LLC returns line with word0=0xDEAD_BEEF two cycles after request. Expect llc_r_addr=0x1000 held high until the fill, instr_data=0xDEAD_BEEF one cycle after the fill, miss_count=1, hit_count=0.
- Streaming hits: after the fill, fetch 0x1000,0x1004,...,0x103C on consecutive cycles. Expect 16 consecutive instr_valid pulses with the correct words, fetch_ready=1 throughout, hit_count=16.
- Conflict: fetch 0x1000 then 0x1800 (same index with 32×64 B) → second access misses and evicts; refetching 0x1000 misses again. Expect miss_count=3.
- Misaligned: fetch 0x1002. Expect instr_valid=1, instr_fault=1 next cycle, no llc_r_addr_valid, counters unchanged.
- Flush mid-miss: miss on 0x2000, assert flush while in MISS. Expect llc_r_addr_valid=0 next cycle, no instr_valid, state IDLE. Refetching 0x1000 misses.
- Reset mid-miss plus saturation: pulse reset low during MISS, expect all outputs at reset values asynchronously. Force miss_count near 32'hFFFF_FFFE, run 3 misses, expect it to stick at 32'hFFFF_FFFF.
